frame_capture_packer: RTL
=========================

# frame_capture_packer

Parametrised pixel-capture packer in the camera pipeline: takes one RGB pixel per clock from the debayer stage and captures exactly one armed frame. Applies an X/Y window, converts each pixel to a selectable compact format and packs pixels little-endian into DATA_WIDTH-bit words with sequential word addresses. Feeds the frame-buffer write port and flags image completion to the host interface.

## Interface
- DATA_WIDTH, 128, packed output word width; multiple of 16, ≥16
- ADDR_WIDTH, 14, word-address width
- PIXEL_WIDTH, 10, per-channel input width; ≥8
- pixel_clock_in  in  1  sole clock
- pixel_reset_n_in  in  1  reset, asynchronous, active-low
- red_data_in / green_data_in / blue_data_in  in  PIXEL_WIDTH each  pixel channels
- line_valid_in  in  1  pixel valid within line
- frame_valid_in  in  1  frame envelope
- start_capture_in  in  1  arm request (level or pulse)
- x_size_in / y_size_in  in  10 each  window size in pixels/lines from frame origin
- format_in  in  2  0=RGB332, 1=RGB565, 2=GRAY8, 3=GRAY4
- data_out  out  DATA_WIDTH  packed word
- data_valid_out  out  1  one-cycle word strobe
- address_out  out  ADDR_WIDTH  word address of data_out
- image_valid_out  out  1  level: captured frame complete
- overflow_out  out  1  level: words dropped at address limit

## Operation
- FSM IDLE→ARMED→CAPTURE→FLUSH→DONE.
- IDLE: start_capture_in=1 → ARMED; latch format_in, x_size_in, y_size_in.
- ARMED: rising edge (frame_valid_in=1, registered fv_q=0) → CAPTURE. That cycle's pixel is eligible. If frame_valid is already high when armed, wait for the next rising edge.
- CAPTURE: falling edge (frame_valid_in=0, fv_q=1) → FLUSH. start_capture_in is ignored.
- FLUSH: one cycle; emits the partial word zero-padded in the upper lanes if ≥1 lane is filled; → DONE.
- DONE: image_valid_out=1. start_capture_in → ARMED, clears image_valid_out and overflow_out, resets address to 0, re-latches config.
- Window: x counter counts line_valid cycles and clears when line_valid falls. y counter increments on each line_valid fall. Pixel accepted iff CAPTURE, line_valid, x<x_size, y<y_size. Size 0 → no pixels; FLUSH emits nothing; DONE still reached.
- Formats: RGB332={R[P-1:P-3],G[P-1:P-3],B[P-1:P-2]}. RGB565={R[P-1:P-5],G[P-1:P-6],B[P-1:P-5]}. Luma Y=(R+2G+B)>>2 in PIXEL_WIDTH+2-bit sum. GRAY8=Y top 8 bits, GRAY4=Y top 4 bits.
- Packing: pixels per word = DATA_WIDTH/bpp (128: 16, 8, 16, 32). First accepted pixel occupies bits [bpp-1:0].
- Address: first word 0, +1 per emitted word. After the word at 2^ADDR_WIDTH−1 is emitted, later words are suppressed (no data_valid_out) and overflow_out=1 until re-armed. No wrap.

## Timing
- Reset: all outputs 0, FSM IDLE, counters 0, fv_q=0.
- Latency: data_valid_out is high the cycle after the pixel completing a word is sampled; data_out and address_out are registered with it.
- Back-to-back full words are allowed on consecutive cycles (GRAY4 at 128 bits: every 32 pixels).
- Word completes on the last accepted pixel: normal emit; FLUSH emits nothing extra.
- Flush word strobes the cycle after the falling edge is sampled. image_valid_out rises the following cycle, so it is never coincident with data_valid_out.
- Asynchronous reset mid-frame: immediate return to IDLE; partial word discarded.

## Configuration
- FRAME_CAPTURE_GRAY_EN defined: luma datapath present; formats 2/3 as specified.
- Not defined: no luma logic; format_in values 2/3 behave exactly as RGB332.

## Structure
- Package frame_capture_pkg: format enum (FMT_RGB332…FMT_GRAY4), FSM state enum, bits-per-pixel function.
- Sub-module pixel_format_convert: combinational pixel→formatted lane plus bpp; holds the luma logic under the macro.

## Test plan
- RGB332, 128-bit, 4×2 window, R=G=B=10'h3FF over 8 pixels → single flush word 64'h0 upper, low 64 bits all FF, address 0, then image_valid_out.
- RGB565, 16×1 window → two words at addresses 0,1, each lane 16'hFFFF for white; no flush word.
- GRAY8 with R=10'd0, G=10'd512, B=10'd1023 → lane = (2047>>2)[9:2] = 8'd127.
- start_capture_in asserted mid-frame → no capture until next frame_valid rise; words start at address 0.
- ADDR_WIDTH=2, GRAY4, 160 pixels → 4 words emitted, fifth suppressed, overflow_out=1, image_valid_out=1.
- x_size_in=0 → zero data_valid_out strobes; image_valid_out asserts 2 cycles after the frame_valid fall.

Source files
------------

// File: rtl/frame_capture_pkg.sv
// Shared types for the frame capture packer: pixel formats, FSM states and
// the bits-per-pixel lookup used to size packing lanes.
package frame_capture_pkg;

  typedef enum logic [1:0] {
    FMT_RGB332 = 2'd0,
    FMT_RGB565 = 2'd1,
    FMT_GRAY8  = 2'd2,
    FMT_GRAY4  = 2'd3
  } fmt_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_FLUSH,
    ST_DONE
  } state_e;

  localparam int BPP_W = 5;

  function automatic logic [BPP_W-1:0] fmt_bpp(fmt_e fmt);
    case (fmt)
      FMT_RGB565: return 5'd16;
      FMT_GRAY4:  return 5'd4;
      default:    return 5'd8;
    endcase
  endfunction

endpackage

// File: rtl/frame_capture_packer_if.sv
// Pixel input / packed word output bundle of the frame capture packer.
interface frame_capture_packer_if #(
  parameter int DATA_WIDTH  = 128,
  parameter int ADDR_WIDTH  = 14,
  parameter int PIXEL_WIDTH = 10
);
  logic [PIXEL_WIDTH-1:0] red_data_in;
  logic [PIXEL_WIDTH-1:0] green_data_in;
  logic [PIXEL_WIDTH-1:0] blue_data_in;
  logic                   line_valid_in;
  logic                   frame_valid_in;
  logic                   start_capture_in;
  logic [9:0]             x_size_in;
  logic [9:0]             y_size_in;
  logic [1:0]             format_in;
  logic [DATA_WIDTH-1:0]  data_out;
  logic                   data_valid_out;
  logic [ADDR_WIDTH-1:0]  address_out;
  logic                   image_valid_out;
  logic                   overflow_out;

  modport master (
    output red_data_in, green_data_in, blue_data_in, line_valid_in,
           frame_valid_in, start_capture_in, x_size_in, y_size_in, format_in,
    input  data_out, data_valid_out, address_out, image_valid_out, overflow_out
  );

  modport slave (
    input  red_data_in, green_data_in, blue_data_in, line_valid_in,
           frame_valid_in, start_capture_in, x_size_in, y_size_in, format_in,
    output data_out, data_valid_out, address_out, image_valid_out, overflow_out
  );
endinterface

// File: rtl/pixel_format_convert.sv
// Combinational RGB -> compact lane conversion, lane zero-extended to 16 bits.
// Luma formats exist only when FRAME_CAPTURE_GRAY_EN is defined.
module pixel_format_convert
  import frame_capture_pkg::*;
#(
  parameter int PIXEL_WIDTH = 10
) (
  input  fmt_e                   fmt,
  input  logic [PIXEL_WIDTH-1:0] red,
  input  logic [PIXEL_WIDTH-1:0] green,
  input  logic [PIXEL_WIDTH-1:0] blue,
  output logic [15:0]            lane,
  output logic [BPP_W-1:0]       bpp
);
  localparam int P  = PIXEL_WIDTH;
  localparam int SW = PIXEL_WIDTH + 2;

  fmt_e eff_fmt;

`ifdef FRAME_CAPTURE_GRAY_EN
  logic [SW-1:0] luma_sum;
  // top bits of (R+2G+B)>>2 are taken straight from the unshifted sum
  assign luma_sum = SW'(red) + (SW'(green) << 1) + SW'(blue);
  assign eff_fmt  = fmt;
`else
  assign eff_fmt  = (fmt == FMT_RGB565) ? FMT_RGB565 : FMT_RGB332;
`endif

  always_comb begin
    lane = '0;
    case (eff_fmt)
      FMT_RGB565: lane = {5'(red >> (P-5)), 6'(green >> (P-6)), 5'(blue >> (P-5))};
`ifdef FRAME_CAPTURE_GRAY_EN
      FMT_GRAY8:  lane = {8'h00, 8'(luma_sum >> (P-6))};
      FMT_GRAY4:  lane = {12'h000, 4'(luma_sum >> (P-2))};
`endif
      default:    lane = {8'h00, 3'(red >> (P-3)), 3'(green >> (P-3)), 2'(blue >> (P-2))};
    endcase
  end

  assign bpp = fmt_bpp(eff_fmt);

endmodule

// File: rtl/frame_capture_packer.sv
// Captures one armed frame, windows it, converts pixels and packs them
// little-endian into addressed words. Optional luma formats: FRAME_CAPTURE_GRAY_EN.
module frame_capture_packer
  import frame_capture_pkg::*;
#(
  parameter int DATA_WIDTH  = 128,
  parameter int ADDR_WIDTH  = 14,
  parameter int PIXEL_WIDTH = 10
) (
  input logic                 pixel_clock_in,
  input logic                 pixel_reset_n_in,
  frame_capture_packer_if.slave bus
);
  localparam int POS_W = $clog2(DATA_WIDTH) + 1;

  state_e                 state_q, state_d;
  logic                   fv_q, lv_q;
  logic [10:0]            x_q, x_d, y_q, y_d;
  fmt_e                   cfg_fmt_q, cfg_fmt_d;
  logic [9:0]             cfg_x_q, cfg_x_d, cfg_y_q, cfg_y_d;
  logic [DATA_WIDTH-1:0]  word_q, word_d;
  logic [POS_W-1:0]       pos_q, pos_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   addr_full_q, addr_full_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   dv_q, dv_d;
  logic [ADDR_WIDTH-1:0]  aout_q, aout_d;
  logic                   ovf_q, ovf_d;

  logic                   fv_rise, fv_fall, in_frame, accept, emit, arm;
  logic [DATA_WIDTH-1:0]  pix_word;
  logic [POS_W-1:0]       pix_pos;
  logic [15:0]            lane;
  logic [BPP_W-1:0]       bpp;

  pixel_format_convert #(.PIXEL_WIDTH(PIXEL_WIDTH)) u_conv (
    .fmt   (cfg_fmt_q),
    .red   (bus.red_data_in),
    .green (bus.green_data_in),
    .blue  (bus.blue_data_in),
    .lane  (lane),
    .bpp   (bpp)
  );

  assign fv_rise  = bus.frame_valid_in & ~fv_q;
  assign fv_fall  = ~bus.frame_valid_in & fv_q;
  // the pixel on the rising-edge cycle already belongs to the frame
  assign in_frame = (state_q == ST_CAPTURE) || (state_q == ST_ARMED && fv_rise);
  assign accept   = in_frame && bus.line_valid_in &&
                    (x_q < {1'b0, cfg_x_q}) && (y_q < {1'b0, cfg_y_q});

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    cfg_fmt_d   = cfg_fmt_q;
    cfg_x_d     = cfg_x_q;
    cfg_y_d     = cfg_y_q;
    addr_d      = addr_q;
    addr_full_d = addr_full_q;
    data_d      = data_q;
    dv_d        = 1'b0;
    aout_d      = aout_q;
    ovf_d       = ovf_q;
    arm         = 1'b0;
    pix_word    = word_q;
    pix_pos     = pos_q;

    if (in_frame) begin
      if (bus.line_valid_in) begin
        x_d = (x_q == '1) ? x_q : x_q + 11'd1;
      end else if (lv_q && state_q == ST_CAPTURE) begin
        x_d = '0;
        y_d = (y_q == '1) ? y_q : y_q + 11'd1;
      end
    end else begin
      x_d = '0;
      y_d = '0;
    end

    if (accept) begin
      pix_word = word_q | (DATA_WIDTH'(lane) << pos_q);
      pix_pos  = pos_q + POS_W'(bpp);
    end

    // a word completed by the last pixel leaves nothing for the flush
    emit   = (pix_pos == POS_W'(DATA_WIDTH)) ||
             (state_q == ST_CAPTURE && fv_fall && pix_pos != '0);
    word_d = emit ? '0 : pix_word;
    pos_d  = emit ? '0 : pix_pos;

    if (emit) begin
      if (addr_full_q) begin
        ovf_d = 1'b1;
      end else begin
        dv_d   = 1'b1;
        data_d = pix_word;
        aout_d = addr_q;
        addr_d = addr_q + 1'b1;
        if (addr_q == '1) addr_full_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE, ST_DONE: arm = bus.start_capture_in;
      ST_ARMED:         if (fv_rise) state_d = ST_CAPTURE;
      ST_CAPTURE:       if (fv_fall) state_d = ST_FLUSH;
      ST_FLUSH:         state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase

    if (arm) begin
      state_d     = ST_ARMED;
      cfg_fmt_d   = fmt_e'(bus.format_in);
      cfg_x_d     = bus.x_size_in;
      cfg_y_d     = bus.y_size_in;
      addr_d      = '0;
      addr_full_d = 1'b0;
      ovf_d       = 1'b0;
      word_d      = '0;
      pos_d       = '0;
    end
  end

  always_ff @(posedge pixel_clock_in or negedge pixel_reset_n_in) begin
    if (!pixel_reset_n_in) begin
      state_q     <= ST_IDLE;
      fv_q        <= 1'b0;
      lv_q        <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      cfg_fmt_q   <= FMT_RGB332;
      cfg_x_q     <= '0;
      cfg_y_q     <= '0;
      word_q      <= '0;
      pos_q       <= '0;
      addr_q      <= '0;
      addr_full_q <= 1'b0;
      data_q      <= '0;
      dv_q        <= 1'b0;
      aout_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fv_q        <= bus.frame_valid_in;
      lv_q        <= bus.line_valid_in;
      x_q         <= x_d;
      y_q         <= y_d;
      cfg_fmt_q   <= cfg_fmt_d;
      cfg_x_q     <= cfg_x_d;
      cfg_y_q     <= cfg_y_d;
      word_q      <= word_d;
      pos_q       <= pos_d;
      addr_q      <= addr_d;
      addr_full_q <= addr_full_d;
      data_q      <= data_d;
      dv_q        <= dv_d;
      aout_q      <= aout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.data_out        = data_q;
  assign bus.data_valid_out  = dv_q;
  assign bus.address_out     = aout_q;
  assign bus.image_valid_out = (state_q == ST_DONE);
  assign bus.overflow_out    = ovf_q;

endmodule
